// File: rtl/piso_serializer.sv
// piso_serializer: pops one word from the FIFO read side and shifts it out
// serially. Each bit is held BIT_CYCLES clocks, frame_o marks the data bits,
// and GAP_CYCLES idle clocks follow each word before the next pop.
// Optional build macro PISO_SERIALIZER_PARITY_EN appends one even-parity bit
// period after the data bits, with frame_o still high.
module piso_serializer #(
   parameter int WIDTH      = 8,
   parameter int BIT_CYCLES = 4,
   parameter int GAP_CYCLES = 2,
   parameter int MSB_FIRST  = 1
) (
   input  logic             clk,
   input  logic             rst_n_i,
   input  logic             enable_i,
   input  logic             fifo_empty_i,
   input  logic [WIDTH-1:0] fifo_rdata_i,
   output logic             fifo_rd_en_o,
   output logic             sdata_o,
   output logic             frame_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [15:0]      word_cnt_o
);

   localparam int BCW = (WIDTH > 1)      ? $clog2(WIDTH)          : 1;
   localparam int CCW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES)     : 1;
   localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
   localparam logic [CCW-1:0] CYC_LAST = CCW'(BIT_CYCLES - 1);
   localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef PISO_SERIALIZER_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_LOAD, S_SHIFT, S_PAR, S_GAP} state_e;
`else
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_LOAD, S_SHIFT, S_GAP} state_e;
`endif

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BCW-1:0]   bit_q,   bit_d;
   logic [CCW-1:0]   cyc_q,   cyc_d;
   logic [GCW-1:0]   gap_q,   gap_d;
   logic [15:0]      cnt_q,   cnt_d;
   logic             sdata_q, sdata_d;
   logic             frame_q, frame_d;
   logic             done_q,  done_d;
   logic             word_end;
`ifdef PISO_SERIALIZER_PARITY_EN
   logic             par_q,   par_d;
`endif

   // Next-state, counters and next registered outputs.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bit_d    = bit_q;
      cyc_d    = cyc_q;
      gap_d    = gap_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      word_end = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_d    = par_q;
`endif
      case (state_q)
         S_IDLE: if (enable_i && !fifo_empty_i) state_d = S_REQ;
         S_REQ:  state_d = S_LOAD;
         // FIFO data is registered, so it is valid one cycle after the pop.
         S_LOAD: begin
            shreg_d = fifo_rdata_i;
            bit_d   = '0;
            cyc_d   = '0;
            state_d = S_SHIFT;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_d   = ^fifo_rdata_i;
`endif
         end
         S_SHIFT: begin
            if (cyc_q == CYC_LAST) begin
               cyc_d   = '0;
               shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
               if (bit_q == BIT_LAST) begin
                  bit_d = '0;
`ifdef PISO_SERIALIZER_PARITY_EN
                  state_d = S_PAR;
`else
                  word_end = 1'b1;
`endif
               end else begin
                  bit_d = bit_q + BCW'(1);
               end
            end else begin
               cyc_d = cyc_q + CCW'(1);
            end
         end
`ifdef PISO_SERIALIZER_PARITY_EN
         S_PAR: begin
            if (cyc_q == CYC_LAST) begin
               cyc_d    = '0;
               word_end = 1'b1;
            end else begin
               cyc_d = cyc_q + CCW'(1);
            end
         end
`endif
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + GCW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Last bit period finished: count the word and pulse done next cycle.
      if (word_end) begin
         done_d  = 1'b1;
         cnt_d   = cnt_q + 16'd1;
         gap_d   = '0;
         state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
      end

      // Outputs are computed from the next state so the flops line up with it.
      frame_d = (state_d == S_SHIFT);
      sdata_d = 1'b0;
      if (state_d == S_SHIFT)
         sdata_d = (MSB_FIRST != 0) ? shreg_d[WIDTH-1] : shreg_d[0];
`ifdef PISO_SERIALIZER_PARITY_EN
      if (state_d == S_PAR) begin
         frame_d = 1'b1;
         sdata_d = par_d;
      end
`endif
   end

   // State, datapath and registered outputs; reset abandons any word in flight.
   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         bit_q   <= '0;
         cyc_q   <= '0;
         gap_q   <= '0;
         cnt_q   <= '0;
         sdata_q <= 1'b0;
         frame_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         bit_q   <= bit_d;
         cyc_q   <= cyc_d;
         gap_q   <= gap_d;
         cnt_q   <= cnt_d;
         sdata_q <= sdata_d;
         frame_q <= frame_d;
         done_q  <= done_d;
`ifdef PISO_SERIALIZER_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // REQ is the only state that pops, so exactly one read per word.
   assign fifo_rd_en_o = (state_q == S_REQ);
   assign busy_o       = (state_q != S_IDLE);
   assign sdata_o      = sdata_q;
   assign frame_o      = frame_q;
   assign done_o       = done_q;
   assign word_cnt_o   = cnt_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (MSB-first with gap, LSB-first with
// no gap) share a behavioural FIFO; a timeline model predicts every cycle.
module tb_piso_serializer;
   localparam int W     = 8;
   localparam int BC_A  = 4;
   localparam int GAP_A = 2;
   localparam int BC_B  = 3;
   localparam int GAP_B = 0;
`ifdef PISO_SERIALIZER_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         en_a = 1'b0, en_b = 1'b0;
   logic [W-1:0] rdata = '0;
   logic [W-1:0] mem [0:255];
   int           wp = 0, rp = 0;
   logic         empty;
   logic         fifo_err = 1'b0;
   logic         sel = 1'b0;
   logic         rd_a, sd_a, fr_a, bz_a, dn_a, rd_b, sd_b, fr_b, bz_b, dn_b;
   logic [15:0]  cnt_a, cnt_b, cnt_obs;
   logic [5:0]   obs;
   int           vectors = 0, miscompares = 0;
   int           cnt_m [2];

   always #5 clk = ~clk;

   piso_serializer u_a (
      .clk(clk), .rst_n_i(rst_n), .enable_i(en_a), .fifo_empty_i(empty),
      .fifo_rdata_i(rdata), .fifo_rd_en_o(rd_a), .sdata_o(sd_a), .frame_o(fr_a),
      .busy_o(bz_a), .done_o(dn_a), .word_cnt_o(cnt_a));

   piso_serializer #(.WIDTH(W), .BIT_CYCLES(BC_B), .GAP_CYCLES(GAP_B), .MSB_FIRST(0)) u_b (
      .clk(clk), .rst_n_i(rst_n), .enable_i(en_b), .fifo_empty_i(empty),
      .fifo_rdata_i(rdata), .fifo_rd_en_o(rd_b), .sdata_o(sd_b), .frame_o(fr_b),
      .busy_o(bz_b), .done_o(dn_b), .word_cnt_o(cnt_b));

   assign empty   = (wp == rp);
   assign obs     = sel ? {rd_a, rd_b, fr_b, sd_b, bz_b, dn_b}
                        : {rd_b, rd_a, fr_a, sd_a, bz_a, dn_a};
   assign cnt_obs = sel ? cnt_b : cnt_a;

   // Behavioural FIFO with registered read data; a pop while empty is an error.
   always @(posedge clk) begin
      if (rd_a || rd_b) begin
         if (wp == rp || (rd_a && rd_b)) fifo_err <= 1'b1;
         else begin
            rdata <= mem[rp % 256];
            rp    <= rp + 1;
         end
      end
   end

   task automatic push(input logic [W-1:0] w);
      mem[wp % 256] = w;
      wp++;
   endtask

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   // Timeline of one word, t=0 being the REQ cycle:
   // {other rd_en, rd_en, frame, sdata, busy, done}.
   function automatic logic [5:0] exp_vec(input int t, input logic [W-1:0] w,
                                          input int bc, input int gap, input bit msb);
      int   dend, k;
      logic fr, sd;
      dend = 2 + (W + PB) * bc;
      fr   = (t >= 2 && t < dend);
      sd   = 1'b0;
      if (fr) begin
         k = (t - 2) / bc;
         if (k < W) sd = msb ? w[W-1-k] : w[k];
         else       sd = ^w;
      end
      return {1'b0, (t == 0), fr, sd, (t < dend + gap), (t == dend)};
   endfunction

   // Follows one word from REQ to its IDLE cycle; optional enable drop / reset.
   task automatic do_word(input logic [W-1:0] w, input int drop_at, input int rst_at);
      int bc, gap, dend, tidle;
      bit msb;
      bc    = sel ? BC_B : BC_A;
      gap   = sel ? GAP_B : GAP_A;
      msb   = sel ? 1'b0 : 1'b1;
      dend  = 2 + (W + PB) * bc;
      tidle = dend + gap;
      for (int t = 0; t <= tidle; t++) begin
         @(negedge clk);
         if (t == rst_at) begin
            #2 rst_n = 1'b0;
            #1 check("async_reset", {obs, cnt_obs}, 0);
            cnt_m[0] = 0;
            cnt_m[1] = 0;
            repeat (3) begin
               @(negedge clk);
               check("reset_hold", {obs, cnt_obs}, 0);
            end
            rst_n = 1'b1;
            return;
         end
         check($sformatf("wave t=%0d", t), obs, exp_vec(t, w, bc, gap, msb));
         if (t == dend) begin
            cnt_m[sel]++;
            check("word_cnt", cnt_obs, cnt_m[sel]);
         end
         if (t == drop_at) begin
            en_a = 1'b0;
            en_b = 1'b0;
         end
      end
   endtask

   task automatic idle_check(input string tag, input int n);
      repeat (n) begin
         @(negedge clk);
         check(tag, obs, 0);
      end
   endtask

   initial begin
      logic [W-1:0] rw;
      int           idle_n;
      cnt_m[0] = 0;
      cnt_m[1] = 0;

      // Reset state of both instances.
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_a", {rd_a, sd_a, fr_a, bz_a, dn_a, cnt_a}, 0);
      check("reset_b", {rd_b, sd_b, fr_b, bz_b, dn_b, cnt_b}, 0);
      rst_n = 1'b1;
      idle_check("idle_after_reset", 2);

      // Single word, MSB first.
      sel = 1'b0; push(8'hA5); en_a = 1'b1;
      do_word(8'hA5, -1, -1);

      // LSB first, no gap.
      en_a = 1'b0; sel = 1'b1; push(8'h01); en_b = 1'b1;
      do_word(8'h01, -1, -1);
      en_b = 1'b0; sel = 1'b0;

      // Three words back-to-back, then rest with the FIFO empty.
      en_a = 1'b1; push(8'h11); push(8'h22); push(8'h33);
      do_word(8'h11, -1, -1);
      do_word(8'h22, -1, -1);
      do_word(8'h33, -1, -1);
      idle_check("idle_empty", 8);

      // Enable drops mid-shift: word completes, queued word waits.
      push(8'hF0); push(8'h99);
      do_word(8'hF0, 2 + 4 * BC_A, -1);
      idle_check("idle_disabled", 6);
      en_a = 1'b1;
      do_word(8'h99, -1, -1);

      // Reset during bit 3, then a clean word.
      push(8'h5A);
      do_word(8'h5A, -1, 2 + 3 * BC_A + 1);
      push(8'h3C);
      do_word(8'h3C, -1, -1);

      // Parity-sensitive words (plain words when parity is not built).
      push(8'h07); do_word(8'h07, -1, -1);
      push(8'h03); do_word(8'h03, -1, -1);

      // Randomized words on either instance with random idle spacing.
      for (int i = 0; i < 10; i++) begin
         en_a = 1'b0; en_b = 1'b0;
         sel    = 1'($urandom_range(0, 1));
         idle_n = $urandom_range(0, 3);
         idle_check("rand_idle", idle_n);
         rw = W'($urandom);
         push(rw);
         if (sel) en_b = 1'b1; else en_a = 1'b1;
         do_word(rw, -1, -1);
      end
      en_a = 1'b0; en_b = 1'b0;
      idle_check("idle_end", 3);
      check("fifo_no_underflow", {31'd0, fifo_err}, 0);
      check("fifo_drained", rp, wp);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
